lfsr_keystream_gen: RTL and testbench

Parametrised Fibonacci LFSR keystream generator. Successor to the fixed 64-bit divided-clock generator. Runs on a single system clock and paces steps with an internal tick-enable divider instead of a derived clock. Adds width and tap generalisation, seed-load handshake, zero-seed protection, and packed keystream words with valid/ready backpressure. Sits between key/seed setup logic and the stream-cipher XOR datapath.

---
 rtl/lfsr_keystream_gen.sv | 108 ++++++++++
 tb/tb_lfsr_keystream_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_keystream_gen.sv
// Fibonacci LFSR keystream generator: tick-enable paced stepping, seed-load handshake
// with zero-seed substitution, and OUT_W-bit packed keystream words with valid/ready.
module lfsr_keystream_gen #(
    parameter int                WIDTH        = 64,
    parameter logic [WIDTH-1:0]  TAPS         = 64'hD800000000000000,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = 64'h0000000000000001,
    parameter int                DIV_N        = 8,
    parameter int                OUT_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_seed_valid,
    input  logic [WIDTH-1:0] i_seed,
    output logic             o_seed_ready,
    output logic             o_seed_zero,
    output logic [WIDTH-1:0] o_lfsr,
    output logic             o_ks_bit,
    output logic [OUT_W-1:0] o_ks_word,
    output logic             o_ks_valid,
    input  logic             i_ks_ready
);
    localparam int DIV_W  = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam int PACK_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_N - 1);
    localparam logic [PACK_W-1:0] PACK_LAST = PACK_W'(OUT_W - 1);

    logic [WIDTH-1:0]  state_reg, state_next;
    logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
    logic [PACK_W-1:0] pack_cnt_reg, pack_cnt_next;
    logic [OUT_W-1:0]  word_reg, word_next;
    logic              valid_reg, valid_next;
    logic              seed_zero_reg, seed_zero_next;
    logic              seed_ready_reg;

    logic stall, run, tick, seed_load, word_done, fb;

    always_comb begin
        stall     = valid_reg & ~i_ks_ready;
        run       = i_enable & ~stall;
        tick      = run & (div_cnt_reg == DIV_LAST);
        seed_load = i_seed_valid & seed_ready_reg;
        word_done = tick & (pack_cnt_reg == PACK_LAST);
        fb        = ^(state_reg & TAPS);
    end

    // Each word bit captures the outgoing MSB when the pack pointer sits on it.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pack
        assign word_next[gi] = seed_load ? 1'b0 :
                               (tick && (pack_cnt_reg == PACK_W'(gi))) ? state_reg[WIDTH-1] :
                               word_reg[gi];
    end

    always_comb begin
        state_next     = state_reg;
        div_cnt_next   = div_cnt_reg;
        pack_cnt_next  = pack_cnt_reg;
        valid_next     = valid_reg;
        seed_zero_next = 1'b0;
        if (seed_load) begin
            // A zero seed would lock the register, so substitute the default.
            state_next     = (i_seed == '0) ? DEFAULT_SEED : i_seed;
            seed_zero_next = (i_seed == '0);
            div_cnt_next   = '0;
            pack_cnt_next  = '0;
            valid_next     = 1'b0;
        end else begin
            if (run)
                div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
            if (tick) begin
                state_next    = {state_reg[WIDTH-2:0], fb};
                pack_cnt_next = word_done ? '0 : pack_cnt_reg + 1'b1;
            end
            if (word_done)
                valid_next = 1'b1;
            else if (valid_reg && i_ks_ready)
                valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= DEFAULT_SEED;
            div_cnt_reg    <= '0;
            pack_cnt_reg   <= '0;
            word_reg       <= '0;
            valid_reg      <= 1'b0;
            seed_zero_reg  <= 1'b0;
            seed_ready_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_cnt_reg    <= div_cnt_next;
            pack_cnt_reg   <= pack_cnt_next;
            word_reg       <= word_next;
            valid_reg      <= valid_next;
            seed_zero_reg  <= seed_zero_next;
            seed_ready_reg <= 1'b1;
        end
    end

    assign o_lfsr       = state_reg;
    assign o_ks_bit     = state_reg[WIDTH-1];
    assign o_ks_word    = word_reg;
    assign o_ks_valid   = valid_reg;
    assign o_seed_ready = seed_ready_reg;
    assign o_seed_zero  = seed_zero_reg;

endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// Bench for lfsr_keystream_gen: an 8-bit DIV_N=1 instance for sequence/handshake work
// and a default-parameter instance for divider pacing.
module tb_lfsr_keystream_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_en, a_sv, a_sready, a_szero, a_bit, a_valid, a_ready;
    logic [7:0] a_seed, a_lfsr, a_word;

    logic        b_rst, b_en, b_sv, b_sready, b_szero, b_bit, b_valid, b_ready;
    logic [63:0] b_seed, b_lfsr;
    logic [7:0]  b_word;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_state;
    logic [7:0] m_word;
    int         m_pack;
    logic [7:0] exp_q[$];

    lfsr_keystream_gen #(
        .WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01), .DIV_N(1), .OUT_W(8)
    ) dut8 (
        .i_clk(clk), .i_rst(a_rst), .i_enable(a_en), .i_seed_valid(a_sv), .i_seed(a_seed),
        .o_seed_ready(a_sready), .o_seed_zero(a_szero), .o_lfsr(a_lfsr), .o_ks_bit(a_bit),
        .o_ks_word(a_word), .o_ks_valid(a_valid), .i_ks_ready(a_ready)
    );

    lfsr_keystream_gen dut64 (
        .i_clk(clk), .i_rst(b_rst), .i_enable(b_en), .i_seed_valid(b_sv), .i_seed(b_seed),
        .o_seed_ready(b_sready), .o_seed_zero(b_szero), .o_lfsr(b_lfsr), .o_ks_bit(b_bit),
        .o_ks_word(b_word), .o_ks_valid(b_valid), .i_ks_ready(b_ready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: shift left, feedback = parity of taps B8, emitted bit is pre-step MSB.
    task automatic m_load(input logic [7:0] s);
        m_state = s;
        m_pack  = 0;
        m_word  = 8'h00;
        exp_q.delete();
    endtask

    task automatic m_step();
        m_word[m_pack] = m_state[7];
        m_pack++;
        if (m_pack == 8) begin
            exp_q.push_back(m_word);
            m_pack = 0;
        end
        m_state = {m_state[6:0], ^(m_state & 8'hB8)};
    endtask

    task automatic a_reseed(input logic [7:0] s);
        a_en = 1'b0; a_sv = 1'b1; a_seed = s;
        cyc();
        a_sv = 1'b0;
        m_load(s);
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        cyc();
        n_tests++; if (a_lfsr !== 8'h01) begin n_fail++; $display("FAIL reset_lfsr8 got %h want 01", a_lfsr); end
        n_tests++; if (a_valid !== 1'b0 || a_word !== 8'h00) begin n_fail++; $display("FAIL reset_out8 valid=%b word=%h want 0/00", a_valid, a_word); end
        n_tests++; if (a_sready !== 1'b0 || a_szero !== 1'b0) begin n_fail++; $display("FAIL reset_seed8 ready=%b zero=%b want 0/0", a_sready, a_szero); end
        n_tests++; if (b_lfsr !== 64'h1 || b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_64 lfsr=%h valid=%b want 1/0", b_lfsr, b_valid); end
        a_rst = 1'b0; b_rst = 1'b0;
        cyc();
        n_tests++; if (a_sready !== 1'b1 || b_sready !== 1'b1) begin n_fail++; $display("FAIL seed_ready_after got %b/%b want 1/1", a_sready, b_sready); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_sequence();
        logic [7:0] tbl [0:7];
        logic [7:0] w;
        tbl = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
        a_reseed(8'h01);
        n_tests++; if (a_lfsr !== 8'h01) begin n_fail++; $display("FAIL seed_load got %h want 01", a_lfsr); end
        a_en = 1'b1; a_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            m_step();
            n_tests++; if (a_lfsr !== m_state) begin n_fail++; $display("FAIL seq_step%0d got %h want %h", k, a_lfsr, m_state); end
            if (k <= 8) begin
                n_tests++; if (a_lfsr !== tbl[k-1]) begin n_fail++; $display("FAIL seq_table%0d got %h want %h", k, a_lfsr, tbl[k-1]); end
            end
            n_tests++; if (a_valid !== ((k % 8) == 0)) begin n_fail++; $display("FAIL seq_valid%0d got %b want %b", k, a_valid, ((k % 8) == 0)); end
            if (a_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL seq_word%0d got %h want none", k, a_word); end
                else begin
                    w = exp_q.pop_front();
                    if (a_word !== w) begin n_fail++; $display("FAIL seq_word%0d got %h want %h", k, a_word, w); end
                end
                if (k == 8) begin
                    n_tests++; if (a_word !== 8'h80) begin n_fail++; $display("FAIL seq_first_word got %h want 80", a_word); end
                end
            end
        end
        a_en = 1'b0;
        $display("[TB] test_sequence done");
    endtask

    task automatic test_period();
        a_reseed(8'h01);
        a_en = 1'b1; a_ready = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            cyc();
            n_tests++;
            if (k < 255) begin
                if (a_lfsr === 8'h01 || a_lfsr === 8'h00) begin n_fail++; $display("FAIL period_step%0d got %h want not 00/01", k, a_lfsr); end
            end else if (a_lfsr !== 8'h01) begin
                n_fail++; $display("FAIL period_255 got %h want 01", a_lfsr);
            end
        end
        a_en = 1'b0;
        $display("[TB] test_period done");
    endtask

    task automatic test_divider();
        logic [63:0] prev;
        int c;
        b_en = 1'b1; b_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            prev = b_lfsr; c = 0;
            do begin cyc(); c++; end while (b_lfsr === prev && c < 20);
            n_tests++; if (c != 8) begin n_fail++; $display("FAIL div_period%0d got %0d cycles want 8", r, c); end
        end
        n_tests++; if (b_lfsr !== 64'h4) begin n_fail++; $display("FAIL div_state got %h want 4", b_lfsr); end
        prev = b_lfsr; c = 0;
        repeat (3) begin cyc(); c++; end
        b_en = 1'b0;
        repeat (3) begin cyc(); c++; end
        b_en = 1'b1;
        do begin cyc(); c++; end while (b_lfsr === prev && c < 30);
        n_tests++; if (c != 11) begin n_fail++; $display("FAIL div_pause got %0d cycles want 11", c); end
        b_en = 1'b0;
        $display("[TB] test_divider done");
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        a_reseed(8'h01);
        a_ready = 1'b0; a_en = 1'b1;
        repeat (8) begin cyc(); m_step(); end
        n_tests++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", a_valid); end
        for (int k = 0; k < 20; k++) begin
            cyc();
            n_tests++;
            if (a_lfsr !== 8'h1C || a_word !== 8'h80 || a_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold%0d got %h/%h/%b want 1c/80/1", k, a_lfsr, a_word, a_valid);
            end
        end
        a_ready = 1'b1;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_word got %h want none", a_word); end
        else begin
            w = exp_q.pop_front();
            if (a_word !== w) begin n_fail++; $display("FAIL bp_word got %h want %h", a_word, w); end
        end
        cyc();
        m_step();
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consume got %b want 0", a_valid); end
        n_tests++; if (a_lfsr !== 8'h38 || a_lfsr !== m_state) begin n_fail++; $display("FAIL bp_resume got %h want 38", a_lfsr); end
        a_en = 1'b0;
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_seed_zero();
        a_reseed(8'h5A);
        a_ready = 1'b0; a_en = 1'b1;
        repeat (8) cyc();
        n_tests++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL sz_pending got %b want 1", a_valid); end
        a_sv = 1'b1; a_seed = 8'h00;
        cyc();
        a_sv = 1'b0; a_en = 1'b0;
        n_tests++; if (a_lfsr !== 8'h01) begin n_fail++; $display("FAIL sz_state got %h want 01", a_lfsr); end
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL sz_discard got %b want 0", a_valid); end
        n_tests++; if (a_szero !== 1'b1) begin n_fail++; $display("FAIL sz_pulse got %b want 1", a_szero); end
        cyc();
        n_tests++; if (a_szero !== 1'b0) begin n_fail++; $display("FAIL sz_pulse_end got %b want 0", a_szero); end
        exp_q.delete();
        a_ready = 1'b1;
        $display("[TB] test_seed_zero done");
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        a_reseed(8'hFF);
        a_ready = 1'b1; a_en = 1'b1;
        repeat (5) cyc();
        a_rst = 1'b1; a_en = 1'b0;
        cyc();
        n_tests++; if (a_lfsr !== 8'h01 || a_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_state got %h/%b want 01/0", a_lfsr, a_valid); end
        a_rst = 1'b0;
        cyc();
        m_load(8'h01);
        a_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            m_step();
            n_tests++; if (a_valid !== (k == 8)) begin n_fail++; $display("FAIL rstmid_valid%0d got %b want %b", k, a_valid, (k == 8)); end
        end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_word got %h want none", a_word); end
        else begin
            w = exp_q.pop_front();
            if (a_word !== w || a_word !== 8'h80) begin n_fail++; $display("FAIL rstmid_word got %h want 80", a_word); end
        end
        a_en = 1'b0;
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_sv = 1'b0; a_seed = 8'h00; a_ready = 1'b0;
        b_rst = 1'b1; b_en = 1'b0; b_sv = 1'b0; b_seed = 64'h0; b_ready = 1'b0;
        m_load(8'h01);
        test_reset();
        test_sequence();
        test_period();
        test_divider();
        test_backpressure();
        test_seed_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
